// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA timing receiver: coordinate recovery and lock tracking
module vga_sync_receiver #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       DE,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       de_out,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [4:0] LOCK_N    = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [3:0] good_cnt, good_cnt_next;
    logic       dirty, dirty_next;
    logic       err;

    logic       hs_cur, hs_prev, vs_cur, vs_prev, de_r;
    logic       hs_edge, vs_edge;
    logic [9:0] nx, ny, x_next, y_next;
    logic       de_exp, sync_mis;
    logic [4:0] cnt_inc;

    // Stage 1: sample the timing pins; history idles high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_cur  <= 1'b1;
            hs_prev <= 1'b1;
            vs_cur  <= 1'b1;
            vs_prev <= 1'b1;
            de_r    <= 1'b0;
        end else begin
            hs_prev <= hs_cur;
            hs_cur  <= h_sync;
            vs_prev <= vs_cur;
            vs_cur  <= v_sync;
            de_r    <= DE;
        end
    end

    assign hs_edge = hs_prev & ~hs_cur;
    assign vs_edge = vs_prev & ~vs_cur;

    // Predicted next coordinate of the free-running raster counters
    always_comb begin
        nx = pixel_x + 10'd1;
        ny = pixel_y;
        if (pixel_x == H_LAST) begin
            nx = 10'd0;
            ny = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end
    end

    assign x_next   = hs_edge ? HS_START : nx;
    assign y_next   = vs_edge ? VS_START : ny;
    assign de_exp   = (nx < H_VIS) && (ny < V_VIS);
    assign sync_mis = (hs_edge ^ (nx == HS_START)) |
                      (vs_edge ^ ((nx == 10'd0) && (ny == VS_START)));
    assign cnt_inc  = {1'b0, good_cnt} + 5'd1;

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= 4'd0;
            dirty    <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            dirty    <= dirty_next;
        end
    end

    // Lock FSM next state: dirty marks a frame that already saw a mismatch
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        dirty_next    = dirty;
        err           = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    state_next    = ACQUIRE;
                    good_cnt_next = 4'd0;
                    dirty_next    = 1'b0;
                end
            end
            ACQUIRE: begin
                if (sync_mis) begin
                    err           = 1'b1;
                    good_cnt_next = 4'd0;
                    dirty_next    = 1'b1;
                end else if (vs_edge) begin
                    dirty_next = 1'b0;
                    if (!dirty) begin
                        good_cnt_next = cnt_inc[3:0];
                        if (cnt_inc >= LOCK_N) begin
                            state_next = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (sync_mis || (de_r != de_exp)) begin
                    err           = 1'b1;
                    state_next    = ACQUIRE;
                    good_cnt_next = 4'd0;
                    dirty_next    = 1'b1;
                end
            end
            default: begin
                state_next    = SEARCH;
                good_cnt_next = 4'd0;
                dirty_next    = 1'b0;
            end
        endcase
    end

    // Stage 2: registered coordinates and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            de_out      <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            de_out      <= de_r;
            locked      <= (state_next == LOCKED);
            frame_start <= (state_next == LOCKED) && (x_next == 10'd0) && (y_next == 10'd0);
            sync_err    <= err;
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver on a reduced raster
module tb_vga_sync_receiver;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 24
    localparam int VT = VV + VF + VS + VB;   // 12
    localparam int HSS = HV + HF;            // 18
    localparam int VSS = VV + VF;            // 8
    localparam int FRAME = HT * VT;          // 288

    logic       clk = 1'b0;
    logic       reset;
    logic       h_sync, v_sync, DE;
    logic [9:0] pixel_x, pixel_y;
    logic       de_out, locked, frame_start, sync_err;

    vga_sync_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .de_out(de_out),
        .locked(locked), .frame_start(frame_start), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // source raster position and the pixel whose result is visible at the current sample
    int sx, sy, sf;
    int lx, ly, lf;
    int px, py, pf;
    logic hs_delay, de_force, vs_drop;
    int hs_delay_y;

    task automatic step();
        logic hs, vs, de;
        hs = !(sx >= HSS && sx < HSS + HS);
        if (hs_delay && sy == hs_delay_y) hs = !(sx >= HSS + 1 && sx < HSS + HS + 1);
        vs = vs_drop ? 1'b1 : !(sy >= VSS && sy < VSS + VS);
        de = (sx < HV && sy < VV) || de_force;
        h_sync = hs;
        v_sync = vs;
        DE = de;
        @(posedge clk);
        #1;
        px = lx; py = ly; pf = lf;
        lx = sx; ly = sy; lf = sf;
        sx++;
        if (sx == HT) begin
            sx = 0;
            sy++;
            if (sy == VT) begin
                sy = 0;
                sf++;
            end
        end
    endtask

    task automatic goto_pos(input int x, input int y);
        for (int i = 0; i < FRAME + 2 && !(sx == x && sy == y); i++) step();
    endtask

    task automatic wait_lock(output int rf, output int rx, output int ry, output int nerr, output bit ok);
        ok = 0; rf = -1; rx = -1; ry = -1; nerr = 0;
        for (int i = 0; i < 6 * FRAME && !ok; i++) begin
            step();
            if (sync_err) nerr++;
            if (locked) begin
                ok = 1; rf = pf; rx = px; ry = py;
            end
        end
    endtask

    task automatic test_reset();
        int errs;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            h_sync = 1'($urandom); v_sync = 1'($urandom); DE = 1'($urandom);
            @(posedge clk); #1;
        end
        checks += 6;
        if (pixel_x !== 10'd0)   begin failures++; $display("FAIL reset_x got=%0d exp=0", pixel_x); end
        if (pixel_y !== 10'd0)   begin failures++; $display("FAIL reset_y got=%0d exp=0", pixel_y); end
        if (de_out !== 1'b0)     begin failures++; $display("FAIL reset_de got=%b exp=0", de_out); end
        if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        if (sync_err !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b exp=0", sync_err); end
        reset = 1'b0; h_sync = 1'b1; v_sync = 1'b1; DE = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sync_err !== 1'b0 || locked !== 1'b0) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL reset_idle got=%0d bad cycles exp=0", errs); end
    endtask

    task automatic test_ideal_lock();
        int rf, rx, ry, nerr, coord_bad, fs_bad, pulses, spacing_bad, unlock, errs, last_fs;
        bit ok;
        sx = 0; sy = 0; sf = 0; lx = 0; ly = 0; lf = 0;
        wait_lock(rf, rx, ry, nerr, ok);
        checks += 4;
        if (!ok)      begin failures++; $display("FAIL lock_timeout got=unlocked exp=locked"); end
        if (rf != 2)  begin failures++; $display("FAIL lock_frame got=%0d exp=2", rf); end
        if (rx != 0 || ry != VSS) begin failures++; $display("FAIL lock_pos got=(%0d,%0d) exp=(0,%0d)", rx, ry, VSS); end
        if (nerr != 0) begin failures++; $display("FAIL lock_errs got=%0d exp=0", nerr); end
        coord_bad = 0; fs_bad = 0; pulses = 0; spacing_bad = 0; unlock = 0; errs = 0; last_fs = -1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            step();
            if (pixel_x !== 10'(px) || pixel_y !== 10'(py)) coord_bad++;
            if (frame_start !== (px == 0 && py == 0)) fs_bad++;
            if (locked !== 1'b1) unlock++;
            if (sync_err !== 1'b0) errs++;
            if (frame_start === 1'b1) begin
                pulses++;
                if (last_fs >= 0 && c - last_fs != FRAME) spacing_bad++;
                last_fs = c;
            end
        end
        checks += 6;
        if (coord_bad != 0)   begin failures++; $display("FAIL ideal_coords got=%0d bad exp=0", coord_bad); end
        if (fs_bad != 0)      begin failures++; $display("FAIL ideal_fs_pos got=%0d bad exp=0", fs_bad); end
        if (pulses != 3)      begin failures++; $display("FAIL ideal_fs_count got=%0d exp=3", pulses); end
        if (spacing_bad != 0) begin failures++; $display("FAIL ideal_fs_spacing got=%0d bad exp=0", spacing_bad); end
        if (unlock != 0)      begin failures++; $display("FAIL ideal_unlock got=%0d exp=0", unlock); end
        if (errs != 0)        begin failures++; $display("FAIL ideal_err got=%0d exp=0", errs); end
    endtask

    task automatic test_hsync_delay();
        int f, nerr, e1x, e2x, x_after, rf, rx, ry, werr;
        bit ok;
        goto_pos(0, 3);
        f = sf; hs_delay = 1'b1; hs_delay_y = 3;
        nerr = 0; e1x = -1; e2x = -1; x_after = -1;
        for (int i = 0; i < HT + 1; i++) begin
            step();
            if (py == 3 && sync_err === 1'b1) begin
                nerr++;
                if (nerr == 1) e1x = px;
                if (nerr == 2) begin e2x = px; x_after = int'(pixel_x); end
            end
        end
        hs_delay = 1'b0;
        checks += 5;
        if (nerr != 2)     begin failures++; $display("FAIL hdelay_errs got=%0d exp=2", nerr); end
        if (e1x != HSS)    begin failures++; $display("FAIL hdelay_err1_x got=%0d exp=%0d", e1x, HSS); end
        if (e2x != HSS + 1) begin failures++; $display("FAIL hdelay_err2_x got=%0d exp=%0d", e2x, HSS + 1); end
        if (x_after != HSS) begin failures++; $display("FAIL hdelay_reload got=%0d exp=%0d", x_after, HSS); end
        if (locked !== 1'b0) begin failures++; $display("FAIL hdelay_locked got=%b exp=0", locked); end
        wait_lock(rf, rx, ry, werr, ok);
        checks++;
        if (!ok || rf != f + 2 || ry != VSS || rx != 0)
            begin failures++; $display("FAIL hdelay_relock got=f%0d(%0d,%0d) exp=f%0d(0,%0d)", rf, rx, ry, f + 2, VSS); end
    endtask

    task automatic test_de_glitch();
        int f, nerr, ex, ey, coord_bad, unlock_seen, rf, rx, ry, werr;
        bit ok;
        goto_pos(20, 2);
        f = sf;
        de_force = 1'b1;
        step();
        de_force = 1'b0;
        nerr = 0; ex = -1; ey = -1; coord_bad = 0; unlock_seen = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (pixel_x !== 10'(px) || pixel_y !== 10'(py)) coord_bad++;
            if (sync_err === 1'b1) begin
                nerr++;
                if (nerr == 1) begin ex = px; ey = py; unlock_seen = (locked === 1'b0); end
            end
        end
        checks += 4;
        if (nerr != 1)     begin failures++; $display("FAIL deglitch_errs got=%0d exp=1", nerr); end
        if (ex != 20 || ey != 2) begin failures++; $display("FAIL deglitch_pos got=(%0d,%0d) exp=(20,2)", ex, ey); end
        if (unlock_seen != 1) begin failures++; $display("FAIL deglitch_locked got=%0d exp=1 (unlocked)", unlock_seen); end
        if (coord_bad != 0) begin failures++; $display("FAIL deglitch_coords got=%0d bad exp=0", coord_bad); end
        wait_lock(rf, rx, ry, werr, ok);
        checks++;
        if (!ok || rf != f + 2) begin failures++; $display("FAIL deglitch_relock got=f%0d exp=f%0d", rf, f + 2); end
    endtask

    task automatic test_vsync_drop();
        int f, nerr, ex, ey, coord_bad, wrap_ok, prev_y, rf, rx, ry, werr;
        bit ok;
        goto_pos(0, 0);
        f = sf;
        vs_drop = 1'b1;
        nerr = 0; ex = -1; ey = -1; coord_bad = 0; wrap_ok = 0; prev_y = -1;
        for (int i = 0; i < FRAME + 2; i++) begin
            if (i == FRAME) vs_drop = 1'b0;
            step();
            if (pixel_x !== 10'(px) || pixel_y !== 10'(py)) coord_bad++;
            if (pf == f + 1 && px == 0 && py == 0 && prev_y == VT - 1 && pixel_y === 10'd0) wrap_ok = 1;
            prev_y = int'(pixel_y);
            if (sync_err === 1'b1) begin
                nerr++;
                if (nerr == 1) begin ex = px; ey = py; end
            end
        end
        checks += 5;
        if (nerr != 1)     begin failures++; $display("FAIL vdrop_errs got=%0d exp=1", nerr); end
        if (ex != 0 || ey != VSS) begin failures++; $display("FAIL vdrop_pos got=(%0d,%0d) exp=(0,%0d)", ex, ey, VSS); end
        if (locked !== 1'b0) begin failures++; $display("FAIL vdrop_locked got=%b exp=0", locked); end
        if (coord_bad != 0) begin failures++; $display("FAIL vdrop_coords got=%0d bad exp=0", coord_bad); end
        if (wrap_ok != 1)  begin failures++; $display("FAIL vdrop_wrap got=%0d exp=1", wrap_ok); end
        wait_lock(rf, rx, ry, werr, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL vdrop_relock got=unlocked exp=locked"); end
    endtask

    task automatic test_reset_mid();
        int f, rf, rx, ry, nerr;
        bit ok;
        goto_pos(10, 5);
        f = sf;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 6;
        if (pixel_x !== 10'd0)    begin failures++; $display("FAIL midrst_x got=%0d exp=0", pixel_x); end
        if (pixel_y !== 10'd0)    begin failures++; $display("FAIL midrst_y got=%0d exp=0", pixel_y); end
        if (de_out !== 1'b0)      begin failures++; $display("FAIL midrst_de got=%b exp=0", de_out); end
        if (locked !== 1'b0)      begin failures++; $display("FAIL midrst_locked got=%b exp=0", locked); end
        if (frame_start !== 1'b0) begin failures++; $display("FAIL midrst_fs got=%b exp=0", frame_start); end
        if (sync_err !== 1'b0)    begin failures++; $display("FAIL midrst_err got=%b exp=0", sync_err); end
        wait_lock(rf, rx, ry, nerr, ok);
        checks += 2;
        if (!ok || rf != f + 2 || rx != 0 || ry != VSS)
            begin failures++; $display("FAIL midrst_relock got=f%0d(%0d,%0d) exp=f%0d(0,%0d)", rf, rx, ry, f + 2, VSS); end
        if (nerr != 0) begin failures++; $display("FAIL midrst_errs got=%0d exp=0", nerr); end
    endtask

    initial begin
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1; DE = 1'b0;
        hs_delay = 1'b0; de_force = 1'b0; vs_drop = 1'b0; hs_delay_y = 0;
        sx = 0; sy = 0; sf = 0; lx = 0; ly = 0; lf = 0; px = 0; py = 0; pf = 0;
        test_reset();
        test_ideal_lock();
        test_hsync_delay();
        test_de_glitch();
        test_vsync_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
